// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe types: cell encodings, winner codes, board FSM states
// and the table of eight winning lines.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        ILLEGAL = 2'b01,
        X       = 2'b10,
        O       = 2'b11
    } cellStateType;

    localparam logic [1:0] O_WIN  = 2'b11;
    localparam logic [1:0] X_WIN  = 2'b10;
    localparam logic [1:0] TIE    = 2'b01;
    localparam logic [1:0] NO_WIN = 2'b00;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;

    // Entry i lives at [12*i +: 12] as three cell numbers, first cell in the top nibble:
    // rows, then columns, then the two diagonals.
    localparam logic [95:0] LINE_TABLE = {
        12'h246, 12'h048, 12'h258, 12'h147,
        12'h036, 12'h678, 12'h345, 12'h012
    };

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } board_state_t;

    // Cell number of position k (0..2) within line 'line'.
    function automatic logic [3:0] line_cell(input logic [2:0] line, input int unsigned k);
        logic [11:0] entry;
        entry = LINE_TABLE[12*int'(line) +: 12];
        return entry[4*(2-k) +: 4];
    endfunction

endpackage

// File: rtl/line_check.sv
// Combinational test of one line: all three cells equal and occupied.
module line_check
    import tictactoe_pkg::*;
(
    input  logic [1:0] cell_a,
    input  logic [1:0] cell_b,
    input  logic [1:0] cell_c,
    output logic       match,
    output logic [1:0] code
);

    // Match flag and the winner code of the owning player.
    always_comb begin
        match = (cell_a == cell_b) && (cell_b == cell_c) && (cell_a != EMPTY);
        code  = NO_WIN;
        if (match) begin
            code = (cell_a == O) ? O_WIN : X_WIN;
        end
    end

endmodule

// File: rtl/game_board.sv
// Tic-tac-toe board: accepts moves, scans one line per cycle after each move
// and latches win/tie. Optional macro BOARD_MOVE_COUNT_EN adds a moveCount
// output and derives board-full from it instead of from the board image.
module game_board
    import tictactoe_pkg::*;
(
    input  logic        ph1,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [3:0]  addr,
    input  logic [1:0]  cellState,
    output logic [17:0] gBoard,
    output logic        busy,
    output logic        gameIsDone,
    output logic [1:0]  winner,
    output logic        moveErr
`ifdef BOARD_MOVE_COUNT_EN
    ,
    output logic [3:0]  moveCount
`endif
);

    board_state_t state_q, state_d;
    logic [17:0]  board_q, board_d;
    logic [2:0]   idx_q, idx_d;
    logic         pend_q, pend_d;
    logic [1:0]   pend_code_q, pend_code_d;
    logic [1:0]   winner_q, winner_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic         move_err_q, move_err_d;
`ifdef BOARD_MOVE_COUNT_EN
    logic [3:0]   cnt_q, cnt_d;
`endif

    logic       wr_req;
    logic       wr_legal;
    logic       board_full;
    logic       ln_match;
    logic [1:0] ln_code;
    logic [1:0] ln_a, ln_b, ln_c;
    logic       fin_match;
    logic [1:0] fin_code;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] a);
        logic [1:0] v;
        v = EMPTY;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (a == i[3:0]) v = b[2*i +: 2];
        end
        return v;
    endfunction

    // Cells of the line currently being scanned.
    always_comb begin
        ln_a = cell_at(board_q, line_cell(idx_q, 0));
        ln_b = cell_at(board_q, line_cell(idx_q, 1));
        ln_c = cell_at(board_q, line_cell(idx_q, 2));
    end

    line_check u_line_check (
        .cell_a (ln_a),
        .cell_b (ln_b),
        .cell_c (ln_c),
        .match  (ln_match),
        .code   (ln_code)
    );

    // Write classification and board-full detection.
    always_comb begin
        wr_req   = (addr != 4'hF) && (cellState != EMPTY);
        wr_legal = (addr <= 4'd8) && (cellState != ILLEGAL) && (cell_at(board_q, addr) == EMPTY);
`ifdef BOARD_MOVE_COUNT_EN
        board_full = (cnt_q == 4'd9);
`else
        board_full = 1'b1;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (board_q[2*i +: 2] == EMPTY) board_full = 1'b0;
        end
`endif
        // The last line's own match counts alongside any earlier latched one.
        fin_match = pend_q | ln_match;
        fin_code  = pend_q ? pend_code_q : ln_code;
    end

    // Next-state logic for the IDLE/SCAN/DONE controller and its outputs.
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        winner_d    = winner_q;
        done_d      = done_q;
        busy_d      = busy_q;
        move_err_d  = 1'b0;
`ifdef BOARD_MOVE_COUNT_EN
        cnt_d       = cnt_q;
`endif
        if (clear) begin
            state_d     = IDLE;
            board_d     = '0;
            idx_d       = '0;
            pend_d      = 1'b0;
            pend_code_d = NO_WIN;
            winner_d    = NO_WIN;
            done_d      = 1'b0;
            busy_d      = 1'b0;
`ifdef BOARD_MOVE_COUNT_EN
            cnt_d       = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (wr_req) begin
                        if (wr_legal) begin
                            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                                if (addr == i[3:0]) board_d[2*i +: 2] = cellState;
                            end
                            state_d     = SCAN;
                            busy_d      = 1'b1;
                            idx_d       = '0;
                            pend_d      = 1'b0;
                            pend_code_d = NO_WIN;
`ifdef BOARD_MOVE_COUNT_EN
                            cnt_d       = cnt_q + 4'd1;
`endif
                        end else begin
                            move_err_d = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    move_err_d = wr_req;
                    if (ln_match && !pend_q) begin
                        pend_d      = 1'b1;
                        pend_code_d = ln_code;
                    end
                    if (idx_q == 3'(NUM_LINES - 1)) begin
                        busy_d = 1'b0;
                        idx_d  = '0;
                        if (fin_match) begin
                            winner_d = fin_code;
                            done_d   = 1'b1;
                            state_d  = DONE;
                        end else if (board_full) begin
                            winner_d = TIE;
                            done_d   = 1'b1;
                            state_d  = DONE;
                        end else begin
                            winner_d = NO_WIN;
                            state_d  = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                DONE: begin
                    move_err_d = wr_req;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            board_q     <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_code_q <= NO_WIN;
            winner_q    <= NO_WIN;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            move_err_q  <= 1'b0;
`ifdef BOARD_MOVE_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            winner_q    <= winner_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            move_err_q  <= move_err_d;
`ifdef BOARD_MOVE_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign gBoard     = board_q;
    assign busy       = busy_q;
    assign gameIsDone = done_q;
    assign winner     = winner_q;
    assign moveErr    = move_err_q;
`ifdef BOARD_MOVE_COUNT_EN
    assign moveCount  = cnt_q;
`endif

endmodule
